refclk_timebase_ctrl: RTL and testbench
=======================================

Name: refclk_timebase_ctrl

Overview:
- Supervises the reference-clock strobe generator and chooses the design's 1 Hz timebase source.
- Source is the refclk-derived 1 Hz strobe while the reference is healthy, and a sysclk-derived fallback divider when the reference is absent or lost.
- Also generates the fast-set tick used while a set button is held.
- Sits between the reference-clock strobe block and the time-of-day counters.

Parameters:
SYS_CLK_HZ, 5_000_000, sysclk frequency; fallback 1 Hz divider modulus
REF_CLK_HZ, 32_768, reference strobes per second; modulus for fast tick in LOCKED
REF_TIMEOUT, 1024, sysclk cycles without a refclk strobe before the reference is declared missing
LOCK_EDGES, 16, consecutive in-time refclk strobes required to lock
FAST_HZ, 8, fast-set tick rate

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_en  input  1  block enable
i_refclk_stb  input  1  one-cycle strobe per reference clock rising edge
i_refclk_1hz_stb  input  1  one-cycle strobe per second from the refclk divider
i_fast_set  input  1  level; set button held (already synchronised)
o_refclk_en  output  1  enable to the strobe generator
o_1hz_stb  output  1  selected 1 Hz tick, one cycle wide
o_fast_stb  output  1  fast-set tick, one cycle wide
o_locked  output  1  high in LOCKED
o_ref_lost  output  1  high in HOLDOVER
o_state  output  2  IDLE=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all counters 0.
  - All outputs 0; o_state=0.
- Registers and latency: all outputs are registered; every response appears 1 cycle after the causing input.
- i_en low:
  - Next state is IDLE from any state; all counters cleared.
  - o_1hz_stb, o_fast_stb and o_refclk_en are 0.
- o_refclk_en = (state != IDLE).
- Gap counter:
  - Counts sysclk cycles since the last i_refclk_stb.
  - Cleared to 0 on i_refclk_stb; saturates at REF_TIMEOUT.
  - Timeout event = count reaches REF_TIMEOUT, asserted for one cycle only.
  - If a strobe and a would-be timeout coincide, the strobe wins: no timeout.
- Edge counter: counts consecutive in-time strobes; saturates at LOCK_EDGES.
- FSM:
  - IDLE -> ACQUIRE when i_en=1; edge counter=0.
  - ACQUIRE, on each i_refclk_stb: edge counter +1. On reaching LOCK_EDGES -> LOCKED.
  - ACQUIRE, on timeout: edge counter=0; remain in ACQUIRE.
  - LOCKED, on timeout -> HOLDOVER.
  - HOLDOVER, on i_refclk_stb -> ACQUIRE with edge counter=1.
- Fallback divider:
  - Counts 0..SYS_CLK_HZ-1; its wrap is the fallback tick.
  - In LOCKED it is cleared on every i_refclk_1hz_stb, so the first HOLDOVER tick lands SYS_CLK_HZ cycles after the last reference tick.
- 1 Hz candidate source:
  - LOCKED: candidate = i_refclk_1hz_stb.
  - ACQUIRE/HOLDOVER: candidate = fallback tick.
- Spacing guard:
  - A candidate is emitted on o_1hz_stb only if at least SYS_CLK_HZ/2 cycles have elapsed since the previous emitted tick; otherwise it is dropped.
  - Spacing counter saturates; reset/IDLE leave it saturated, so the first tick is always allowed.
- Fast tick:
  - While i_fast_set=0: fast counter held at 0; o_fast_stb=0.
  - On the i_fast_set rising edge: o_fast_stb pulses the next cycle.
  - Thereafter one pulse per period: REF_CLK_HZ/FAST_HZ refclk strobes in LOCKED, SYS_CLK_HZ/FAST_HZ sysclk cycles otherwise.
  - Fast counter is cleared on any state change.
- Widths:
  - Counters sized by $clog2 of their moduli; all comparisons are unsigned.
  - Integer division of moduli truncates; each modulus must be >= 2.

Test Plan:
Bench parameters for all cases: SYS_CLK_HZ=1000, REF_CLK_HZ=16, REF_TIMEOUT=100, LOCK_EDGES=4, FAST_HZ=4.

1. Lock-in:
   - Stimulus: reset, i_en=1, i_refclk_stb every 40 cycles.
   - Required: o_state=1 after 1 cycle; o_state=2 and o_locked=1 the cycle after the 4th strobe; o_refclk_en=1 throughout.
2. Acquire restart:
   - Stimulus: 3 strobes, then a 150-cycle gap, then strobes every 40 cycles.
   - Required: o_state stays 1; lock occurs only after 4 fresh strobes; o_1hz_stb pulses every 1000 cycles from the fallback divider meanwhile.
3. Loss and holdover:
   - Stimulus: LOCKED, i_refclk_1hz_stb at T; strobes stop.
   - Required: o_state=3 and o_ref_lost=1 exactly 100 cycles after the last strobe (+1 registered); next o_1hz_stb at T+1000+1.
4. Re-acquire and spacing guard:
   - Stimulus: from HOLDOVER, resume strobes; i_refclk_1hz_stb 200 cycles after the last emitted tick.
   - Required: o_state goes 1 then 2; the close reference tick is suppressed; the next one is emitted.
5. Fast set:
   - Stimulus: i_fast_set=1 in ACQUIRE.
   - Required: o_fast_stb the next cycle, then every 250 cycles. In LOCKED: one pulse per 4 refclk strobes. Release: no further pulses.
6. Async reset / enable drop:
   - Stimulus: assert i_reset mid-LOCKED between clock edges.
   - Required: all outputs 0 immediately. Separately, i_en=0 gives o_state=0 and o_refclk_en=0 the next cycle; re-enable restarts in ACQUIRE.

Source files
------------

// File: rtl/refclk_timebase_ctrl.sv
// refclk_timebase_ctrl: supervises the reference-clock strobe, selects the
// 1 Hz timebase source (reference divider vs. sysclk fallback divider) and
// produces the fast-set tick while a set button is held.
module refclk_timebase_ctrl #(
   parameter int SYS_CLK_HZ  = 5_000_000,
   parameter int REF_CLK_HZ  = 32_768,
   parameter int REF_TIMEOUT = 1024,
   parameter int LOCK_EDGES  = 16,
   parameter int FAST_HZ     = 8
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic       i_refclk_stb,
   input  logic       i_refclk_1hz_stb,
   input  logic       i_fast_set,
   output logic       o_refclk_en,
   output logic       o_1hz_stb,
   output logic       o_fast_stb,
   output logic       o_locked,
   output logic       o_ref_lost,
   output logic [1:0] o_state
);
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ACQUIRE  = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;
   localparam logic [1:0] ST_HOLDOVER = 2'd3;

   localparam int HALF_SEC = SYS_CLK_HZ / 2;
   localparam int FAST_REF = REF_CLK_HZ / FAST_HZ;
   localparam int FAST_SYS = SYS_CLK_HZ / FAST_HZ;
   localparam int FAST_MAX = (FAST_REF > FAST_SYS) ? FAST_REF : FAST_SYS;

   localparam int GW = $clog2(REF_TIMEOUT + 1);
   localparam int EW = $clog2(LOCK_EDGES + 1);
   localparam int DW = $clog2(SYS_CLK_HZ);
   localparam int SW = $clog2(HALF_SEC + 1);
   localparam int FW = $clog2(FAST_MAX);

   localparam logic [GW-1:0] GAP_SAT   = GW'(REF_TIMEOUT);
   localparam logic [GW-1:0] GAP_LAST  = GW'(REF_TIMEOUT - 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(LOCK_EDGES - 1);
   localparam logic [EW-1:0] EDGE_SAT  = EW'(LOCK_EDGES);
   localparam logic [DW-1:0] DIV_LAST  = DW'(SYS_CLK_HZ - 1);
   localparam logic [SW-1:0] SPC_SAT   = SW'(HALF_SEC);
   localparam logic [FW-1:0] FREF_LAST = FW'(FAST_REF - 1);
   localparam logic [FW-1:0] FSYS_LAST = FW'(FAST_SYS - 1);

   logic [1:0]    state, state_nxt;
   logic [GW-1:0] gap_cnt;
   logic [EW-1:0] edge_cnt, edge_nxt;
   logic [DW-1:0] div_cnt;
   logic [SW-1:0] spc_cnt;
   logic [FW-1:0] fast_cnt;
   logic          fset_q;
   logic          clr, timeout, fb_tick, cand, emit;

   // Everything restarts while disabled or sitting in IDLE.
   assign clr     = !i_en || (state == ST_IDLE);
   // One-shot: fires on the cycle the gap count would reach the limit; a strobe wins.
   assign timeout = !clr && !i_refclk_stb && (gap_cnt == GAP_LAST);
   assign fb_tick = (div_cnt == DIV_LAST);
   assign cand    = (state == ST_LOCKED) ? i_refclk_1hz_stb :
                    ((state == ST_ACQUIRE || state == ST_HOLDOVER) && fb_tick);
   assign emit    = i_en && cand && (spc_cnt >= SPC_SAT);

   assign o_state     = state;
   assign o_refclk_en = (state != ST_IDLE);
   assign o_locked    = (state == ST_LOCKED);
   assign o_ref_lost  = (state == ST_HOLDOVER);

   // Next-state and lock-edge bookkeeping.
   always_comb begin
      state_nxt = state;
      edge_nxt  = edge_cnt;
      if (!i_en) begin
         state_nxt = ST_IDLE;
         edge_nxt  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_ACQUIRE;
               edge_nxt  = '0;
            end
            ST_ACQUIRE: begin
               if (i_refclk_stb) begin
                  if (edge_cnt == EDGE_LAST) begin
                     state_nxt = ST_LOCKED;
                     edge_nxt  = EDGE_SAT;
                  end else begin
                     edge_nxt = edge_cnt + EW'(1);
                  end
               end else if (timeout) begin
                  edge_nxt = '0;
               end
            end
            ST_LOCKED: begin
               if (timeout) state_nxt = ST_HOLDOVER;
            end
            default: begin
               if (i_refclk_stb) begin
                  state_nxt = ST_ACQUIRE;
                  edge_nxt  = EW'(1);
               end
            end
         endcase
      end
   end

   // State register and saturating strobe-gap counter.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         edge_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         edge_cnt <= edge_nxt;
         if (clr || i_refclk_stb)   gap_cnt <= '0;
         else if (gap_cnt != GAP_SAT) gap_cnt <= gap_cnt + GW'(1);
      end
   end

   // Fallback divider, tick spacing guard and the selected 1 Hz output.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         div_cnt   <= '0;
         spc_cnt   <= SPC_SAT;
         o_1hz_stb <= 1'b0;
      end else if (clr) begin
         div_cnt   <= '0;
         spc_cnt   <= SPC_SAT;
         o_1hz_stb <= 1'b0;
      end else begin
         // Re-phasing on each reference tick makes holdover continue seamlessly.
         if (state == ST_LOCKED && i_refclk_1hz_stb) div_cnt <= '0;
         else if (fb_tick)                           div_cnt <= '0;
         else                                        div_cnt <= div_cnt + DW'(1);
         // Counts cycles elapsed including the current one.
         if (emit)                    spc_cnt <= SW'(1);
         else if (spc_cnt != SPC_SAT) spc_cnt <= spc_cnt + SW'(1);
         o_1hz_stb <= emit;
      end
   end

   // Fast-set tick: immediate pulse on press, then periodic while held.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         fset_q     <= 1'b0;
         fast_cnt   <= '0;
         o_fast_stb <= 1'b0;
      end else if (!i_en) begin
         fset_q     <= 1'b0;
         fast_cnt   <= '0;
         o_fast_stb <= 1'b0;
      end else begin
         fset_q     <= i_fast_set;
         o_fast_stb <= 1'b0;
         if (!i_fast_set) begin
            fast_cnt <= '0;
         end else if (!fset_q) begin
            o_fast_stb <= 1'b1;
            fast_cnt   <= '0;
         end else if (state_nxt != state) begin
            fast_cnt <= '0;
         end else if (state == ST_LOCKED) begin
            if (i_refclk_stb) begin
               if (fast_cnt == FREF_LAST) begin
                  o_fast_stb <= 1'b1;
                  fast_cnt   <= '0;
               end else begin
                  fast_cnt <= fast_cnt + FW'(1);
               end
            end
         end else if (fast_cnt == FSYS_LAST) begin
            o_fast_stb <= 1'b1;
            fast_cnt   <= '0;
         end else begin
            fast_cnt <= fast_cnt + FW'(1);
         end
      end
   end
endmodule

// File: tb/tb_refclk_timebase_ctrl.sv
// Bench for refclk_timebase_ctrl: cycle-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_refclk_timebase_ctrl;
   localparam int SYS  = 1000;
   localparam int REFC = 16;
   localparam int TO   = 100;
   localparam int LOCK = 4;
   localparam int FAST = 4;
   localparam int BIG  = 1 << 30;

   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   logic i_en = 1'b0;
   logic i_refclk_stb = 1'b0;
   logic i_refclk_1hz_stb = 1'b0;
   logic i_fast_set = 1'b0;
   logic o_refclk_en, o_1hz_stb, o_fast_stb, o_locked, o_ref_lost;
   logic [1:0] o_state;

   int n_total = 0;
   int n_bad   = 0;

   // Model: plain integer time-since-event bookkeeping.
   int m_state      = 0;
   int m_since_stb  = 0;
   int m_edges      = 0;
   int m_phase      = 0;
   int m_since_emit = BIG;
   int m_fast_cnt   = 0;
   bit m_fset_prev  = 1'b0;
   bit e_1hz        = 1'b0;
   bit e_fast       = 1'b0;

   refclk_timebase_ctrl #(
      .SYS_CLK_HZ(SYS), .REF_CLK_HZ(REFC), .REF_TIMEOUT(TO),
      .LOCK_EDGES(LOCK), .FAST_HZ(FAST)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en),
      .i_refclk_stb(i_refclk_stb), .i_refclk_1hz_stb(i_refclk_1hz_stb),
      .i_fast_set(i_fast_set), .o_refclk_en(o_refclk_en), .o_1hz_stb(o_1hz_stb),
      .o_fast_stb(o_fast_stb), .o_locked(o_locked), .o_ref_lost(o_ref_lost),
      .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   task automatic model_clear();
      m_state = 0; m_since_stb = 0; m_edges = 0; m_phase = 0;
      m_since_emit = BIG; m_fast_cnt = 0; m_fset_prev = 1'b0;
      e_1hz = 1'b0; e_fast = 1'b0;
   endtask

   task automatic model_step();
      int nxt;
      bit tout, cand, rise;
      if (!i_en) begin
         model_clear();
         return;
      end
      tout = (m_state != 0) && !i_refclk_stb && (m_since_stb + 1 == TO);
      if (m_state == 2) cand = i_refclk_1hz_stb;
      else              cand = (m_state != 0) && (m_phase == SYS - 1);
      e_1hz = cand && (m_since_emit >= SYS / 2);
      nxt = m_state;
      case (m_state)
         0: begin nxt = 1; m_edges = 0; end
         1: begin
            if (i_refclk_stb) begin
               m_edges++;
               if (m_edges >= LOCK) nxt = 2;
            end else if (tout) m_edges = 0;
         end
         2: if (tout) nxt = 3;
         default: if (i_refclk_stb) begin nxt = 1; m_edges = 1; end
      endcase
      rise = i_fast_set && !m_fset_prev;
      e_fast = 1'b0;
      if (!i_fast_set) m_fast_cnt = 0;
      else if (rise) begin e_fast = 1'b1; m_fast_cnt = 0; end
      else if (nxt != m_state) m_fast_cnt = 0;
      else if (m_state == 2) begin
         if (i_refclk_stb) begin
            m_fast_cnt++;
            if (m_fast_cnt == REFC / FAST) begin e_fast = 1'b1; m_fast_cnt = 0; end
         end
      end else begin
         m_fast_cnt++;
         if (m_fast_cnt == SYS / FAST) begin e_fast = 1'b1; m_fast_cnt = 0; end
      end
      m_fset_prev = i_fast_set;
      if (m_state == 0) begin
         m_since_stb = 0; m_phase = 0; m_since_emit = BIG;
      end else begin
         m_since_stb  = i_refclk_stb ? 0 : m_since_stb + 1;
         m_phase      = (m_state == 2 && i_refclk_1hz_stb) ? 0 : (m_phase + 1) % SYS;
         m_since_emit = e_1hz ? 1 : m_since_emit + 1;
      end
      m_state = nxt;
   endtask

   always @(posedge i_clk or posedge i_reset) begin
      if (i_reset) model_clear();
      else         model_step();
   end

   // Per-cycle comparison against the model.
   initial begin
      logic [6:0] got, exp;
      forever begin
         @(posedge i_clk);
         #1;
         if (!i_reset) begin
            got = {o_refclk_en, o_1hz_stb, o_fast_stb, o_locked, o_ref_lost, o_state};
            exp = {m_state != 0, e_1hz, e_fast, m_state == 2, m_state == 3, 2'(m_state)};
            n_total++;
            if (got !== exp) begin
               n_bad++;
               $display("FAIL cycle_model t=%0t got=%b exp=%b", $time, got, exp);
            end
         end
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
      end
   endtask

   task automatic clk1(input bit en, input bit stb, input bit hz);
      @(negedge i_clk);
      i_en = en; i_refclk_stb = stb; i_refclk_1hz_stb = hz;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int fast_after_release;
      bit s, h;
      #3;
      chk("reset_outs", int'({o_refclk_en, o_1hz_stb, o_fast_stb, o_locked, o_ref_lost, o_state}), 0);
      i_reset = 1'b0;

      // Lock-in, loss/holdover, re-acquire with spacing guard.
      clk1(1, 0, 0);
      chk("t1_acquire", o_state, 1);
      for (int i = 1; i <= 2400; i++) begin
         s = (i <= 160 && i % 40 == 0) || (i >= 1190 && (i - 1190) % 40 == 0);
         h = (i == 180) || (i == 1380) || (i == 2380);
         clk1(1, s, h);
         case (i)
            100:  chk("t1_refclk_en", o_refclk_en, 1);
            159:  chk("t1_pre_lock", o_state, 1);
            160:  begin chk("t1_lock_state", o_state, 2); chk("t1_locked", o_locked, 1); end
            180:  chk("t3_ref_tick", o_1hz_stb, 1);
            259:  chk("t3_pre_loss", o_state, 2);
            260:  begin chk("t3_holdover", o_state, 3); chk("t3_ref_lost", o_ref_lost, 1); end
            1179: chk("t3_no_early_tick", o_1hz_stb, 0);
            1180: chk("t3_fallback_tick", o_1hz_stb, 1);
            1190: begin chk("t4_reacquire", o_state, 1); chk("t4_lost_clear", o_ref_lost, 0); end
            1309: chk("t4_pre_relock", o_state, 1);
            1310: chk("t4_relock", o_state, 2);
            1380: chk("t4_close_tick_dropped", o_1hz_stb, 0);
            2380: chk("t4_next_tick", o_1hz_stb, 1);
            default: ;
         endcase
      end

      // Enable drop and restart.
      clk1(0, 0, 0);
      chk("t6_en_drop_state", o_state, 0);
      chk("t6_en_drop_refclk_en", o_refclk_en, 0);
      clk1(1, 0, 0);
      chk("t6_reenable", o_state, 1);

      // Acquire restart with fallback ticks, then fast set in ACQUIRE and LOCKED.
      fast_after_release = 0;
      for (int i = 1; i <= 2900; i++) begin
         if (i < 2300) s = ((i % 230) == 40) || ((i % 230) == 80) || ((i % 230) == 120);
         else          s = (i % 40 == 0);
         if (i == 300)  i_fast_set = 1'b1;
         if (i == 2700) i_fast_set = 1'b0;
         clk1(1, s, 0);
         if (i > 2700 && o_fast_stb) fast_after_release++;
         case (i)
            220:  chk("t2_timeout_stays_acq", o_state, 1);
            300:  chk("t5_press_pulse", o_fast_stb, 1);
            301:  chk("t5_single_pulse", o_fast_stb, 0);
            549:  chk("t5_pre_period", o_fast_stb, 0);
            550:  chk("t5_period_pulse", o_fast_stb, 1);
            999:  chk("t2_no_early_fb", o_1hz_stb, 0);
            1000: chk("t2_fb_tick1", o_1hz_stb, 1);
            2000: chk("t2_fb_tick2", o_1hz_stb, 1);
            2439: chk("t2_pre_lock", o_state, 1);
            2440: chk("t2_lock", o_state, 2);
            2550: chk("t5_locked_no_sys_pulse", o_fast_stb, 0);
            2599: chk("t5_locked_pre", o_fast_stb, 0);
            2600: chk("t5_locked_pulse", o_fast_stb, 1);
            default: ;
         endcase
      end
      chk("t5_release_quiet", fast_after_release, 0);
      chk("t6_pre_reset_locked", o_state, 2);

      // Asynchronous reset between clock edges.
      @(posedge i_clk);
      #2;
      i_reset = 1'b1;
      #1;
      chk("t6_async_outs", int'({o_refclk_en, o_1hz_stb, o_fast_stb, o_locked, o_ref_lost, o_state}), 0);
      @(negedge i_clk);
      i_reset = 1'b0;
      clk1(1, 0, 0);
      chk("t6_restart_acq", o_state, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
